// File: rtl/arith_pipe_if.sv
// Issue and writeback handshake bundle for the pipelined ALU.
// The core side drives the master modport, the arithmetic unit takes the slave modport.
interface arith_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 6
);
    logic             issue_valid;
    logic             issue_ready;
    logic [TAG_W-1:0] issue_tag;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  inst;
    logic [XLEN-1:0]  rs1_value;
    logic [XLEN-1:0]  rs2_value;
    logic             wb_valid;
    logic             wb_ready;
    logic [TAG_W-1:0] wb_tag;
    logic [XLEN-1:0]  wb_value;
    logic             wb_illegal;

    modport master (
        output issue_valid, issue_tag, pc, inst, rs1_value, rs2_value, wb_ready,
        input  issue_ready, wb_valid, wb_tag, wb_value, wb_illegal
    );

    modport slave (
        input  issue_valid, issue_tag, pc, inst, rs1_value, rs2_value, wb_ready,
        output issue_ready, wb_valid, wb_tag, wb_value, wb_illegal
    );
endinterface

// File: rtl/arith_pipe.sv
// Pipelined RV32I ALU-class execution unit: decode/compute into stage 1,
// then STAGES-1 plain register stages with collapsing bubbles and flush.
module arith_pipe #(
    parameter int XLEN   = 32,
    parameter int TAG_W  = 6,
    parameter int STAGES = 1
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        flush_i,
    arith_pipe_if.slave bus,
    output logic        busy_o
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    logic [6:0]      opcode_s;
    logic [2:0]      funct3_s;
    logic [6:0]      funct7_s;
    logic            is_op_s;
    logic [XLEN-1:0] imm_i_s;
    logic [XLEN-1:0] imm_u_s;
    logic [XLEN-1:0] op2_s;
    logic [4:0]      shamt_s;
    logic            lt_s;
    logic            ltu_s;
    logic [XLEN-1:0] alu_s;
    logic            illegal_s;
    logic [XLEN-1:0] result_s;
    logic            unused_s;

    logic              issue_fire_s;
    logic              chain_s;
    logic [STAGES-1:0] free_s;
    logic [STAGES-1:0] in_valid_s;
    logic [STAGES-1:0] in_illegal_s;
    logic [TAG_W-1:0]  in_tag_s   [STAGES];
    logic [XLEN-1:0]   in_value_s [STAGES];

    logic [STAGES-1:0] valid_r;
    logic [STAGES-1:0] illegal_r;
    logic [TAG_W-1:0]  tag_r   [STAGES];
    logic [XLEN-1:0]   value_r [STAGES];

    // Register fields are never needed here: only the values arrive on ports.
    assign unused_s = ^{bus.inst[19:15], bus.inst[11:7]};

    // Instruction field extraction and second-operand selection
    always_comb begin
        opcode_s = bus.inst[6:0];
        funct3_s = bus.inst[14:12];
        funct7_s = bus.inst[31:25];
        is_op_s  = (opcode_s == OPC_OP);
        imm_i_s  = {{20{bus.inst[31]}}, bus.inst[31:20]};
        imm_u_s  = {bus.inst[31:12], 12'd0};
        if (is_op_s) begin
            op2_s   = bus.rs2_value;
            shamt_s = bus.rs2_value[4:0];
        end else begin
            op2_s   = imm_i_s;
            shamt_s = bus.inst[24:20];
        end
        lt_s  = ($signed(bus.rs1_value) < $signed(op2_s));
        ltu_s = (bus.rs1_value < op2_s);
    end

    // Shared OP / OP-IMM arithmetic, selected by funct3
    always_comb begin
        alu_s = {XLEN{1'b0}};
        case (funct3_s)
            3'b000: begin
                if (is_op_s && funct7_s[5]) begin
                    alu_s = bus.rs1_value - op2_s;
                end else begin
                    alu_s = bus.rs1_value + op2_s;
                end
            end
            3'b001: alu_s = bus.rs1_value << shamt_s;
            3'b010: alu_s = {{(XLEN-1){1'b0}}, lt_s};
            3'b011: alu_s = {{(XLEN-1){1'b0}}, ltu_s};
            3'b100: alu_s = bus.rs1_value ^ op2_s;
            3'b101: begin
                if (funct7_s[5]) begin
                    alu_s = $unsigned($signed(bus.rs1_value) >>> shamt_s);
                end else begin
                    alu_s = bus.rs1_value >> shamt_s;
                end
            end
            3'b110: alu_s = bus.rs1_value | op2_s;
            3'b111: alu_s = bus.rs1_value & op2_s;
            default: alu_s = {XLEN{1'b0}};
        endcase
    end

    // Encoding legality and final result selection
    always_comb begin
        illegal_s = 1'b0;
        result_s  = {XLEN{1'b0}};
        case (opcode_s)
            OPC_OP: begin
                if (funct7_s == F7_BASE) begin
                    illegal_s = 1'b0;
                end else if (funct7_s == F7_ALT) begin
                    illegal_s = !((funct3_s == 3'b000) || (funct3_s == 3'b101));
                end else begin
                    illegal_s = 1'b1;
                end
                result_s = illegal_s ? {XLEN{1'b0}} : alu_s;
            end
            OPC_OP_IMM: begin
                case (funct3_s)
                    3'b001:  illegal_s = (funct7_s != F7_BASE);
                    3'b101:  illegal_s = (funct7_s != F7_BASE) && (funct7_s != F7_ALT);
                    default: illegal_s = 1'b0;
                endcase
                result_s = illegal_s ? {XLEN{1'b0}} : alu_s;
            end
            OPC_LUI:            result_s = imm_u_s;
            OPC_AUIPC:          result_s = bus.pc + imm_u_s;
            OPC_JAL, OPC_JALR:  result_s = bus.pc + 32'd4;
            default: begin
                illegal_s = 1'b1;
                result_s  = {XLEN{1'b0}};
            end
        endcase
    end

    // Stage k may load when it or any stage below it is empty, or the sink takes the result
    always_comb begin
        chain_s = bus.wb_ready;
        free_s  = {STAGES{1'b0}};
        for (int k = STAGES - 1; k >= 0; k--) begin
            chain_s   = chain_s || !valid_r[k];
            free_s[k] = chain_s;
        end
    end

    assign issue_fire_s = bus.issue_valid && free_s[0] && !flush_i;

    // What each stage would capture: stage 0 from the issue port, others from their predecessor
    always_comb begin
        in_valid_s[0]   = issue_fire_s;
        in_illegal_s[0] = illegal_s;
        in_tag_s[0]     = bus.issue_tag;
        in_value_s[0]   = result_s;
        for (int k = 1; k < STAGES; k++) begin
            in_valid_s[k]   = valid_r[k-1];
            in_illegal_s[k] = illegal_r[k-1];
            in_tag_s[k]     = tag_r[k-1];
            in_value_s[k]   = value_r[k-1];
        end
    end

    // Stage registers; a full stage that cannot move keeps its contents stable
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_r   <= {STAGES{1'b0}};
            illegal_r <= {STAGES{1'b0}};
            for (int k = 0; k < STAGES; k++) begin
                tag_r[k]   <= {TAG_W{1'b0}};
                value_r[k] <= {XLEN{1'b0}};
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (flush_i) begin
                    valid_r[k] <= 1'b0;
                end else if (free_s[k]) begin
                    valid_r[k] <= in_valid_s[k];
                end
                if (free_s[k] && in_valid_s[k]) begin
                    illegal_r[k] <= in_illegal_s[k];
                    tag_r[k]     <= in_tag_s[k];
                    value_r[k]   <= in_value_s[k];
                end
            end
        end
    end

    assign bus.issue_ready = free_s[0];
    assign bus.wb_valid    = valid_r[STAGES-1];
    assign bus.wb_tag      = tag_r[STAGES-1];
    assign bus.wb_value    = value_r[STAGES-1];
    assign bus.wb_illegal  = illegal_r[STAGES-1];
    assign busy_o          = |valid_r;

endmodule
